forwardjoin: RTL and testbench

- Downstream counterpart of snoopsplit: recombines the forwarder-side packet-memory interfaces of two branches (left/right) into one, so packets leave in arrival order.
- Records each split decision (`choice` at `done`) in an order FIFO.
- Grants the downstream forwarder to the branch at the FIFO head. Skips packets that the branch's filter rejected.
- Joins nest in a tree that mirrors the split tree.

---
 rtl/forwardjoin_pkg.sv | 12 +
 rtl/order_fifo.sv | 53 +++++
 rtl/forwardjoin.sv | 144 ++++++++++++++
 tb/tb_forwardjoin.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/forwardjoin_pkg.sv
// Shared types for the forward-join: FSM states and branch identifiers.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package forwardjoin_pkg;
  typedef enum logic {
    SEL = 1'b0,
    FWD = 1'b1
  } state_t;

  localparam logic LEFT  = 1'b0;
  localparam logic RIGHT = 1'b1;
endpackage

// File: rtl/order_fifo.sv
// 1-bit synchronous FIFO that records which branch each split packet went to.
// Latency: head valid the cycle after the first push; no empty bypass.
// Backpressure: full flags stall; a push while full with no pop is dropped and sets sticky overflow.
module order_fifo #(
  parameter int AW = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic push,
  input  logic din,
  input  logic pop,
  output logic head,
  output logic empty,
  output logic full,
  output logic overflow
);
  localparam int DEPTH = 1 << AW;
  localparam logic [AW:0] ONE = {{AW{1'b0}}, 1'b1};

  logic [DEPTH-1:0] mem;
  logic [AW:0]      wp;
  logic [AW:0]      rp;
  logic             do_pop;
  logic             do_push;

  // Wrap bit differs and index matches: the writer is a full lap ahead.
  assign empty   = (wp == rp);
  assign full    = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rp[AW-1:0]];

  // Pointer, storage and sticky overflow update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem      <= '0;
      wp       <= '0;
      rp       <= '0;
      overflow <= 1'b0;
    end else begin
      if (do_push) begin
        mem[wp[AW-1:0]] <= din;
        wp              <= wp + ONE;
      end
      if (do_pop) begin
        rp <= rp + ONE;
      end
      if (push && full && !do_pop) begin
        overflow <= 1'b1;
      end
    end
  end
endmodule

// File: rtl/forwardjoin.sv
// Merges two branch packet-memory ports into one downstream port in original split order.
// Latency: grant one cycle after the head is ready; FWD data path is pure combinational pass-through.
// Backpressure: order_ready drops when the order FIFO is full; downstream sees ready=0 until the head branch is ready.
module forwardjoin
  import forwardjoin_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 10,
  parameter int LEN_WIDTH  = 11,
  parameter int ORDER_AW   = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  split_done,
  input  logic                  split_choice,
  output logic                  order_ready,
  output logic [ADDR_WIDTH-1:0] rd_addr_left,
  output logic [ADDR_WIDTH-1:0] rd_addr_right,
  output logic                  rd_en_left,
  output logic                  rd_en_right,
  output logic                  done_left,
  output logic                  done_right,
  input  logic [DATA_WIDTH-1:0] rd_data_left,
  input  logic [DATA_WIDTH-1:0] rd_data_right,
  input  logic [LEN_WIDTH-1:0]  len_left,
  input  logic [LEN_WIDTH-1:0]  len_right,
  input  logic                  ready_left,
  input  logic                  ready_right,
  input  logic                  rej_left,
  input  logic                  rej_right,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic                  rd_en,
  input  logic                  done,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic [LEN_WIDTH-1:0]  len,
  output logic                  ready,
  output logic                  overflow
);
  localparam logic [ORDER_AW:0] RMAX = '1;
  localparam logic [ORDER_AW:0] ONE  = {{ORDER_AW{1'b0}}, 1'b1};

  state_t            state;
  logic              sel;
  logic [ORDER_AW:0] rcnt_l;
  logic [ORDER_AW:0] rcnt_r;
  logic              head;
  logic              empty;
  logic              full;
  logic              pop;
  logic              in_fwd;
  logic              skip;
  logic              grant;
  logic              fwd_done;
  logic              head_ready;
  logic [ORDER_AW:0] head_rcnt;

  // Saturating reject counter step; a simultaneous reject and skip cancel out.
  function automatic logic [ORDER_AW:0] cnt_next(input logic [ORDER_AW:0] c,
                                                 input logic inc, input logic dec);
    cnt_next = c;
    if (inc && !dec && (c != RMAX)) cnt_next = c + ONE;
    else if (dec && !inc)           cnt_next = c - ONE;
  endfunction

  order_fifo #(.AW(ORDER_AW)) u_order (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (split_done),
    .din     (split_choice),
    .pop     (pop),
    .head    (head),
    .empty   (empty),
    .full    (full),
    .overflow(overflow)
  );

  assign order_ready = !full;
  assign in_fwd      = (state == FWD);
  assign head_rcnt   = (head == RIGHT) ? rcnt_r : rcnt_l;
  assign head_ready  = (head == RIGHT) ? ready_right : ready_left;
  // A pending reject on the head's branch means that packet never reaches the branch buffer: drop it.
  assign skip        = !in_fwd && !empty && (head_rcnt != '0);
  assign grant       = !in_fwd && !empty && (head_rcnt == '0) && head_ready;
  assign fwd_done    = in_fwd && done;
  assign pop         = skip || fwd_done;

  // Grant / release FSM; sel holds the branch owning the downstream port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= SEL;
      sel   <= LEFT;
    end else begin
      case (state)
        SEL: if (grant) begin
          sel   <= head;
          state <= FWD;
        end
        FWD: if (done) state <= SEL;
        default: state <= SEL;
      endcase
    end
  end

  // Per-branch count of rejected packets still queued in the order FIFO.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rcnt_l <= '0;
      rcnt_r <= '0;
    end else begin
      rcnt_l <= cnt_next(rcnt_l, rej_left,  skip && (head == LEFT));
      rcnt_r <= cnt_next(rcnt_r, rej_right, skip && (head == RIGHT));
    end
  end

  // Downstream-to-branch pass-through while forwarding; idle branch sees zeros.
  always_comb begin
    rd_addr_left  = '0;
    rd_addr_right = '0;
    rd_en_left    = 1'b0;
    rd_en_right   = 1'b0;
    done_left     = 1'b0;
    done_right    = 1'b0;
    rd_data       = '0;
    len           = '0;
    ready         = 1'b0;
    if (in_fwd) begin
      if (sel == RIGHT) begin
        rd_addr_right = rd_addr;
        rd_en_right   = rd_en;
        done_right    = done;
        rd_data       = rd_data_right;
        len           = len_right;
        ready         = ready_right;
      end else begin
        rd_addr_left  = rd_addr;
        rd_en_left    = rd_en;
        done_left     = done;
        rd_data       = rd_data_left;
        len           = len_left;
        ready         = ready_left;
      end
    end
  end
endmodule

// File: tb/tb_forwardjoin.sv
// Randomised and directed bench for forwardjoin against a queue-based order model.
// Latency: model predicts outputs each cycle from its queue of split choices.
// Backpressure: exercises full order FIFO, overflow and held grants.
module tb_forwardjoin;
  logic        clk;
  logic        rst_n;
  logic        split_done, split_choice, order_ready;
  logic [9:0]  rd_addr_left, rd_addr_right, rd_addr;
  logic        rd_en_left, rd_en_right, done_left, done_right;
  logic [63:0] rd_data_left, rd_data_right, rd_data;
  logic [10:0] len_left, len_right, len;
  logic        ready_left, ready_right, rej_left, rej_right;
  logic        rd_en, done, ready, overflow;

  int n_chk = 0;
  int n_fail = 0;

  // Model: queue of split decisions, outstanding rejects per branch, current grant.
  bit ord[$];
  int rl, rr;
  bit m_fwd, m_cur, m_ovf;

  forwardjoin dut (
    .clk(clk), .rst_n(rst_n), .split_done(split_done), .split_choice(split_choice),
    .order_ready(order_ready), .rd_addr_left(rd_addr_left), .rd_addr_right(rd_addr_right),
    .rd_en_left(rd_en_left), .rd_en_right(rd_en_right), .done_left(done_left),
    .done_right(done_right), .rd_data_left(rd_data_left), .rd_data_right(rd_data_right),
    .len_left(len_left), .len_right(len_right), .ready_left(ready_left),
    .ready_right(ready_right), .rej_left(rej_left), .rej_right(rej_right),
    .rd_addr(rd_addr), .rd_en(rd_en), .done(done), .rd_data(rd_data), .len(len),
    .ready(ready), .overflow(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    ord.delete();
    rl = 0; rr = 0;
    m_fwd = 0; m_cur = 0; m_ovf = 0;
  endtask

  task automatic model_check();
    bit fl, fr;
    fl = m_fwd && !m_cur;
    fr = m_fwd && m_cur;
    check("order_ready", order_ready, ord.size() < 16);
    check("overflow", overflow, m_ovf);
    check("ready", ready, m_fwd ? (m_cur ? ready_right : ready_left) : 1'b0);
    check("rd_data", rd_data, m_fwd ? (m_cur ? rd_data_right : rd_data_left) : 64'd0);
    check("len", len, m_fwd ? (m_cur ? len_right : len_left) : 11'd0);
    check("rd_en_left", rd_en_left, fl && rd_en);
    check("rd_en_right", rd_en_right, fr && rd_en);
    check("rd_addr_left", rd_addr_left, fl ? rd_addr : 10'd0);
    check("rd_addr_right", rd_addr_right, fr ? rd_addr : 10'd0);
    check("done_left", done_left, fl && done);
    check("done_right", done_right, fr && done);
  endtask

  // Advance the model by one clock using the inputs applied during that cycle.
  task automatic model_step();
    int sz;
    bit popq, dl, dr, h;
    sz = ord.size();
    popq = 0; dl = 0; dr = 0;
    if (m_fwd) begin
      if (done) begin popq = 1; m_fwd = 0; end
    end else if (sz > 0) begin
      h = ord[0];
      if ((h ? rr : rl) > 0) begin
        popq = 1;
        if (h) dr = 1; else dl = 1;
      end else if (h ? ready_right : ready_left) begin
        m_fwd = 1; m_cur = h;
      end
    end
    if (rej_left && !dl && rl < 31) rl++;
    else if (dl && !rej_left) rl--;
    if (rej_right && !dr && rr < 31) rr++;
    else if (dr && !rej_right) rr--;
    if (popq) void'(ord.pop_front());
    if (split_done) begin
      if (sz < 16 || popq) ord.push_back(split_choice);
      else m_ovf = 1;
    end
  endtask

  task automatic branch_data();
    rd_data_left  = {$urandom, $urandom};
    rd_data_right = {$urandom, $urandom};
    len_left      = 11'($urandom);
    len_right     = 11'($urandom);
  endtask

  task automatic idle();
    split_done = 0; split_choice = 0; rej_left = 0; rej_right = 0;
    rd_en = 0; done = 0; rd_addr = '0;
    branch_data();
  endtask

  // Inputs are set just after a falling edge; check, clock, and return at the next falling edge.
  task automatic cycle();
    #1;
    model_check();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic push(input bit c);
    idle(); split_done = 1; split_choice = c; cycle();
  endtask

  task automatic serve(input int nreads);
    idle(); cycle();
    idle(); cycle();
    for (int i = 0; i < nreads; i++) begin
      idle(); rd_en = 1; rd_addr = 10'(i * 3 + 1); cycle();
    end
    idle(); done = 1; cycle();
  endtask

  task automatic do_reset();
    rst_n = 0; model_reset(); idle();
    @(posedge clk); @(negedge clk);
    rst_n = 1;
  endtask

  initial begin
    rst_n = 1; ready_left = 0; ready_right = 0; idle();
    #2 rst_n = 0;
    model_reset();
    #1;
    check("reset_order_ready", order_ready, 1'b1);
    check("reset_ready", ready, 1'b0);
    check("reset_overflow", overflow, 1'b0);
    @(negedge clk); @(negedge clk);
    rst_n = 1;

    // In-order merge
    ready_left = 1; ready_right = 1;
    push(0); push(1); push(0);
    for (int p = 0; p < 3; p++) serve(4);
    idle(); cycle();

    // Ordering hold: right first, not ready for 20 cycles
    ready_left = 1; ready_right = 0;
    push(1); push(0);
    for (int i = 0; i < 20; i++) begin idle(); cycle(); end
    ready_right = 1;
    serve(2); serve(2);

    // Reject skip
    ready_left = 0; ready_right = 0;
    push(0);
    idle(); rej_left = 1; cycle();
    push(0); push(1);
    ready_left = 1; ready_right = 1;
    serve(3); serve(3);
    idle(); cycle();

    // Full / overflow / push+pop while full
    ready_left = 0; ready_right = 0;
    for (int i = 0; i < 16; i++) push(i[0]);
    check("full_order_ready", order_ready, 1'b0);
    push(1);
    check("overflow_set", overflow, 1'b1);
    idle(); rej_left = 1; cycle();
    push(1);
    check("full_after_pushpop", order_ready, 1'b0);
    ready_left = 1; ready_right = 1;
    for (int i = 0; i < 16; i++) serve(1);

    // Data mux on right branch
    do_reset();
    ready_left = 1; ready_right = 1;
    push(1);
    idle(); cycle();
    for (int i = 0; i < 3; i++) begin
      idle(); rd_en = 1; rd_addr = 10'h2A; cycle();
    end
    idle(); done = 1; cycle();

    // Async reset mid-FWD
    push(0);
    idle(); cycle();
    idle(); rd_en = 1; rd_addr = 10'h11; cycle();
    idle(); rd_en = 1; rd_addr = 10'h12;
    #3 rst_n = 0;
    model_reset();
    #1;
    check("async_ready", ready, 1'b0);
    check("async_rd_en_left", rd_en_left, 1'b0);
    check("async_order_ready", order_ready, 1'b1);
    @(posedge clk); @(negedge clk);
    rst_n = 1;
    idle(); cycle();
    push(0);
    serve(2);

    // Randomised traffic
    for (int i = 0; i < 3000; i++) begin
      idle();
      split_done   = ($urandom_range(0, 3) == 0);
      split_choice = 1'($urandom);
      rej_left     = ($urandom_range(0, 15) == 0);
      rej_right    = ($urandom_range(0, 15) == 0);
      rd_en        = 1'($urandom);
      rd_addr      = 10'($urandom);
      done         = ($urandom_range(0, 4) == 0);
      if ($urandom_range(0, 7) == 0) ready_left  = 1'($urandom);
      if ($urandom_range(0, 7) == 0) ready_right = 1'($urandom);
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
